csa_tree_pipe: RTL and testbench
================================

Name: csa_tree_pipe

Overview:
- Parametrised, pipelined carry-save reduction tree: reduces NUM_OPS operands of WIDTH bits to one redundant sum/carry pair using 3:2 compressor levels.
- Pipeline registers are inserted after every LEVELS_PER_STAGE levels.
- Successor to the fixed 3-input 130-bit carry-save adder. Sits between the partial-product generator and the final carry-propagate adder of the multiplier datapath.
- Adds a valid/ready handshake with backpressure, tag passthrough and synchronous flush.

Parameters:
- WIDTH, 130, operand and result width in bits.
- NUM_OPS, 8, number of operands; legal range 3..33.
- LEVELS_PER_STAGE, 2, compressor levels between pipeline registers; must be >= 1.
- TAG_W, 4, width of sideband tag carried alongside data.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous; drops all in-flight transactions.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set this cycle.
- in_ops  input  NUM_OPS*WIDTH  packed operands; operand i is at [i*WIDTH +: WIDTH].
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result pair valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  redundant sum vector.
- out_carry  output  WIDTH  carry vector, already shifted left 1, bit 0 = 0.
- out_tag  output  TAG_W  tag of the transaction on the output.

Behaviour:
- Level count L:
  - Operand count n=NUM_OPS reduces per level as n -> 2*floor(n/3) + (n mod 3).
  - Iterate until n=2.
  - NUM_OPS=8 gives L=4; NUM_OPS=3 gives L=1.
- Pipeline depth: NSTAGE = ceil(L/LEVELS_PER_STAGE).
  - The last register bank drives the outputs directly; no combinational path from in_ops to out_*.
- Per 3:2 compressor (inputs a, b, c):
  - sum = a^b^c.
  - carry = ((a&b)|(a&c)|(b&c)) << 1, truncated to WIDTH bits (MSB discarded).
  - Leftover operands (n mod 3) pass to the next level unchanged.
- Invariant: (out_sum + out_carry) mod 2^WIDTH == (sum of in_ops) mod 2^WIDTH. Arithmetic is unsigned modulo 2^WIDTH, so signed two's-complement operands work unchanged.
- Operand grouping within a level is fixed and deterministic: groups (0,1,2), (3,4,5), ...; outputs ordered sum0, carry0, sum1, carry1, ..., then leftovers.
- Stage registers:
  - Each stage k has a valid bit v[k] plus data and tag.
  - adv[last] = out_ready | ~v[last].
  - adv[k] = adv[k+1] | ~v[k].
  - Stage k loads from its upstream when adv[k]=1.
  - in_ready = adv[0]. This is a combinational ready chain, and bubbles collapse.
- Latency: NSTAGE cycles from in_valid&in_ready to out_valid with no backpressure. Throughput is 1 per cycle.
- Capacity: NSTAGE transactions. With out_ready held low, in_ready deasserts once all v[k]=1.
- Ordering: strict FIFO. The tag travels with its data unchanged.
- Output stability: while out_valid=1 and out_ready=0, out_sum, out_carry and out_tag hold stable.
- Flush:
  - Clears all v[k] at the next edge. Data registers are don't-care.
  - An in_valid in the same cycle as flush is dropped.
  - out_valid is 0 in the cycle after flush.
- Reset:
  - All v[k]=0, out_valid=0, out_sum=0, out_carry=0, out_tag=0 immediately on rst assertion.
  - Reset asserted mid-operation discards all in-flight data.
  - The first accept is possible in the first cycle after rst deasserts.
- Data registers load only on adv&valid_upstream, for power; functional correctness must not depend on this.

Decomposition:
- Package csa_pkg:
  - Function csa_levels(n) returning L.
  - Function csa_count_after(n, levels) returning the operand count after a given number of levels, used to size the per-stage arrays.
  - Function csa_nstage(n, lps).
  - Constant CSA_MAX_OPS=33.
- Sub-module csa_level: one combinational reduction level.
  - Parameters: WIDTH, N_IN.
  - Packed in/out.
  - Instantiated L times through a generate loop.
- Top-level logic: level instantiation, stage registers, handshake.

Test Plan:
1. Defaults (WIDTH=130, NUM_OPS=8, LPS=2 -> NSTAGE=2); all operands = 1, tag=3, out_ready=1 -> out_valid exactly 2 cycles after accept, out_sum+out_carry = 8 mod 2^130, out_tag=3, out_carry[0]=0.
2. Defaults; all operands = 2^130-1 -> (out_sum+out_carry) mod 2^130 = 2^130-8 (wrap-around, carry MSB discarded).
3. Backpressure: 4 back-to-back transactions with tags 0..3, out_ready=0 for 6 cycles -> in_ready drops after 2 accepts; out_* held stable; on out_ready=1 results emerge with tags 0,1,2,3 in order, one per cycle, each with the correct sum.
4. Flush with 2 transactions in flight and a simultaneous in_valid -> out_valid=0 the next cycle; no stale result ever appears; the next transaction completes with latency 2.
5. Async reset pulsed mid-stream (not aligned to clk) -> all outputs 0 immediately; after release, 100 random transactions with random out_ready match a reference sum model.
6. NUM_OPS=3, LPS=1 (NSTAGE=1); ops 5, 3, 6 -> after 1 cycle out_sum=0, out_carry=14; also sweep NUM_OPS=4, 9, 33 with random data against the modular-sum invariant.

Source files
------------

// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csa_pkg
// Description : Sizing helpers for the pipelined carry-save reduction tree.
// Revision    : 1.0 - initial release
// ============================================================================
package csa_pkg;

    localparam int CSA_MAX_OPS = 33;

    // Operand count remaining after 'levels' rounds of 3:2 compression.
    function automatic int csa_count_after(input int n, input int levels);
        int c;
        c = n;
        for (int i = 0; i < levels; i++) begin
            c = 2 * (c / 3) + (c % 3);
        end
        return c;
    endfunction

    function automatic int csa_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        for (int i = 0; i < CSA_MAX_OPS; i++) begin
            if (c > 2) begin
                c = 2 * (c / 3) + (c % 3);
                l = l + 1;
            end
        end
        return l;
    endfunction

    function automatic int csa_nstage(input int n, input int lps);
        return (csa_levels(n) + lps - 1) / lps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_level.sv
`default_nettype none
// ============================================================================
// Module      : csa_level
// Description : One combinational 3:2 compression level; groups (0,1,2),
//               (3,4,5)... emit sum/carry pairs, leftovers pass through.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_level #(
    parameter int WIDTH = 130,
    parameter int N_IN  = 3
) (
    input  logic [N_IN*WIDTH-1:0]                          i_ops,
    output logic [(2*(N_IN/3) + (N_IN%3))*WIDTH-1:0]       o_ops
);

    localparam int c_ngrp  = N_IN / 3;
    localparam int c_nleft = N_IN % 3;

    for (genvar g = 0; g < c_ngrp; g++) begin : g_grp
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_c;
        logic [WIDTH-1:0] w_maj;

        assign w_a   = i_ops[(3*g)*WIDTH   +: WIDTH];
        assign w_b   = i_ops[(3*g+1)*WIDTH +: WIDTH];
        assign w_c   = i_ops[(3*g+2)*WIDTH +: WIDTH];
        assign w_maj = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);

        assign o_ops[(2*g)*WIDTH   +: WIDTH] = w_a ^ w_b ^ w_c;
        // Carry weight is one bit higher; the top majority bit falls off mod 2^WIDTH.
        assign o_ops[(2*g+1)*WIDTH +: WIDTH] = w_maj << 1;
    end

    for (genvar i = 0; i < c_nleft; i++) begin : g_left
        assign o_ops[(2*c_ngrp+i)*WIDTH +: WIDTH] = i_ops[(3*c_ngrp+i)*WIDTH +: WIDTH];
    end

endmodule
`default_nettype wire

// File: rtl/csa_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : csa_tree_pipe
// Description : Pipelined carry-save reduction tree with valid/ready
//               handshake, tag passthrough and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_tree_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH            = 130,
    parameter int NUM_OPS          = 8,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic [WIDTH-1:0]         out_carry,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int c_levels = csa_levels(NUM_OPS);
    localparam int c_nstage = csa_nstage(NUM_OPS, LEVELS_PER_STAGE);

    logic [c_nstage-1:0] w_v;
    logic [c_nstage-1:0] w_adv;

    // A stage may load when downstream moves or when it holds nothing, so bubbles collapse.
    always_comb begin
        w_adv = '0;
        w_adv[c_nstage-1] = out_ready | ~w_v[c_nstage-1];
        for (int k = c_nstage - 2; k >= 0; k--) begin
            w_adv[k] = w_adv[k+1] | ~w_v[k];
        end
    end

    for (genvar k = 0; k < c_nstage; k++) begin : g_stg
        localparam int c_lvl_first = k * LEVELS_PER_STAGE;
        localparam int c_lvl_end   = ((k + 1) * LEVELS_PER_STAGE < c_levels) ?
                                     (k + 1) * LEVELS_PER_STAGE : c_levels;
        localparam int c_nlvl      = c_lvl_end - c_lvl_first;
        localparam int c_n_in      = csa_count_after(NUM_OPS, c_lvl_first);
        localparam int c_n_out     = csa_count_after(NUM_OPS, c_lvl_end);

        logic [c_n_in*WIDTH-1:0]  w_sin;
        logic                     w_v_up;
        logic [TAG_W-1:0]         w_tag_up;
        logic [c_n_out*WIDTH-1:0] r_data;
        logic [TAG_W-1:0]         r_tag;
        logic                     r_v;

        if (k == 0) begin : g_head
            assign w_sin    = in_ops;
            assign w_v_up   = in_valid;
            assign w_tag_up = in_tag;
        end else begin : g_link
            assign w_sin    = g_stg[k-1].r_data;
            assign w_v_up   = g_stg[k-1].r_v;
            assign w_tag_up = g_stg[k-1].r_tag;
        end

        for (genvar i = 0; i < c_nlvl; i++) begin : g_lv
            localparam int c_li = csa_count_after(NUM_OPS, c_lvl_first + i);
            localparam int c_lo = csa_count_after(NUM_OPS, c_lvl_first + i + 1);

            logic [c_li*WIDTH-1:0] w_lin;
            logic [c_lo*WIDTH-1:0] w_lout;

            if (i == 0) begin : g_first
                assign w_lin = w_sin;
            end else begin : g_next
                assign w_lin = g_lv[i-1].w_lout;
            end

            csa_level #(
                .WIDTH (WIDTH),
                .N_IN  (c_li)
            ) u_level (
                .i_ops (w_lin),
                .o_ops (w_lout)
            );
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v    <= 1'b0;
                r_data <= '0;
                r_tag  <= '0;
            end else begin
                if (flush) begin
                    r_v <= 1'b0;
                end else if (w_adv[k]) begin
                    r_v <= w_v_up;
                end
                // Data only moves with a valid beat; stale contents are never observed.
                if (w_adv[k] && w_v_up) begin
                    r_data <= g_lv[c_nlvl-1].w_lout;
                    r_tag  <= w_tag_up;
                end
            end
        end

        assign w_v[k] = r_v;
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_v[c_nstage-1];
    assign out_sum   = g_stg[c_nstage-1].r_data[WIDTH-1:0];
    assign out_carry = g_stg[c_nstage-1].r_data[2*WIDTH-1:WIDTH];
    assign out_tag   = g_stg[c_nstage-1].r_tag;

endmodule
`default_nettype wire

// File: tb/tb_csa_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_tree_pipe
// Description : Randomised self-checking bench against a modular-sum model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_tree_pipe;

    localparam int W = 130;

    typedef struct {
        logic [W-1:0] sum;
        logic [3:0]   tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic no_flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [8*W-1:0] in_ops = '0;
    logic [3:0] in_tag = '0;
    logic in_ready, out_valid;
    logic [W-1:0] out_sum, out_carry;
    logic [3:0] out_tag;

    logic d3_valid = 1'b0;
    logic [3*W-1:0] d3_ops = '0;
    logic [3:0] d3_tag_in = '0;
    logic d3_ready, d3_ovalid;
    logic [W-1:0] d3_sum, d3_carry;
    logic [3:0] d3_tag;

    logic sw_valid = 1'b0;
    logic sw_ordy = 1'b1;
    logic [33*W-1:0] sw_ops = '0;
    logic [3:0] sw_tag_in = '0;
    logic sw_ready [3];
    logic sw_ovalid [3];
    logic [W-1:0] sw_sum [3];
    logic [W-1:0] sw_carry [3];
    logic [3:0] sw_otag [3];

    int n_cmp = 0;
    int n_err = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    csa_tree_pipe #(.WIDTH(W), .NUM_OPS(8), .LEVELS_PER_STAGE(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_tag(out_tag));

    csa_tree_pipe #(.WIDTH(W), .NUM_OPS(3), .LEVELS_PER_STAGE(1), .TAG_W(4)) dut3 (
        .clk(clk), .rst(rst), .flush(no_flush), .in_valid(d3_valid), .in_ready(d3_ready),
        .in_ops(d3_ops), .in_tag(d3_tag_in), .out_valid(d3_ovalid), .out_ready(sw_ordy),
        .out_sum(d3_sum), .out_carry(d3_carry), .out_tag(d3_tag));

    csa_tree_pipe #(.WIDTH(W), .NUM_OPS(4), .LEVELS_PER_STAGE(2), .TAG_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(no_flush), .in_valid(sw_valid), .in_ready(sw_ready[0]),
        .in_ops(sw_ops[4*W-1:0]), .in_tag(sw_tag_in), .out_valid(sw_ovalid[0]), .out_ready(sw_ordy),
        .out_sum(sw_sum[0]), .out_carry(sw_carry[0]), .out_tag(sw_otag[0]));

    csa_tree_pipe #(.WIDTH(W), .NUM_OPS(9), .LEVELS_PER_STAGE(2), .TAG_W(4)) dut9 (
        .clk(clk), .rst(rst), .flush(no_flush), .in_valid(sw_valid), .in_ready(sw_ready[1]),
        .in_ops(sw_ops[9*W-1:0]), .in_tag(sw_tag_in), .out_valid(sw_ovalid[1]), .out_ready(sw_ordy),
        .out_sum(sw_sum[1]), .out_carry(sw_carry[1]), .out_tag(sw_otag[1]));

    csa_tree_pipe #(.WIDTH(W), .NUM_OPS(33), .LEVELS_PER_STAGE(2), .TAG_W(4)) dut33 (
        .clk(clk), .rst(rst), .flush(no_flush), .in_valid(sw_valid), .in_ready(sw_ready[2]),
        .in_ops(sw_ops), .in_tag(sw_tag_in), .out_valid(sw_ovalid[2]), .out_ready(sw_ordy),
        .out_sum(sw_sum[2]), .out_carry(sw_carry[2]), .out_tag(sw_otag[2]));

    // Reference: plain modular sum of the first n operands.
    function automatic logic [W-1:0] ref_sum(input logic [33*W-1:0] ops, input int n);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = s + ops[i*W +: W];
        return s;
    endfunction

    function automatic logic [33*W-1:0] rand_ops();
        logic [4319:0] t;
        for (int i = 0; i < 135; i++) t[i*32 +: 32] = $urandom;
        return t[33*W-1:0];
    endfunction

    // One clock of stimulus on the default instance; returns what was seen before the edge.
    task automatic drive_cycle(input logic v, input logic [8*W-1:0] ops, input logic [3:0] tag,
                               input logic ordy, input logic fl, output logic acc,
                               output logic ov, output logic fired, output logic [W-1:0] s,
                               output logic [W-1:0] c, output logic [3:0] t);
        in_valid = v; in_ops = ops; in_tag = tag; out_ready = ordy; flush = fl;
        #1;
        acc = v & in_ready & ~fl;
        ov = out_valid;
        fired = out_valid & ordy;
        s = out_sum; c = out_carry; t = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_carry !== '0 || out_tag !== 4'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%0b s=%0h c=%0h t=%0h want all 0",
                     out_valid, out_sum, out_carry, out_tag);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic run_single(input string name, input logic [W-1:0] opv, input logic [W-1:0] want);
        logic [8*W-1:0] ops;
        logic acc, ov, fired;
        logic [W-1:0] s, c;
        logic [3:0] t;
        for (int i = 0; i < 8; i++) ops[i*W +: W] = opv;
        drive_cycle(1'b1, ops, 4'd3, 1'b1, 1'b0, acc, ov, fired, s, c, t);
        n_cmp++;
        if (acc !== 1'b1) begin n_err++; $display("FAIL %s_accept: got %0b want 1", name, acc); end
        drive_cycle(1'b0, '0, 4'd0, 1'b1, 1'b0, acc, ov, fired, s, c, t);
        n_cmp++;
        if (ov !== 1'b0) begin n_err++; $display("FAIL %s_early: got valid %0b want 0", name, ov); end
        drive_cycle(1'b0, '0, 4'd0, 1'b1, 1'b0, acc, ov, fired, s, c, t);
        n_cmp++;
        if (ov !== 1'b1 || W'(s + c) !== want || t !== 4'd3 || c[0] !== 1'b0) begin
            n_err++;
            $display("FAIL %s_result: got v=%0b sum=%0h tag=%0h c0=%0b want v=1 sum=%0h tag=3 c0=0",
                     name, ov, W'(s + c), t, c[0], want);
        end
    endtask

    task automatic test_basic();
        run_single("ones", W'(1), W'(8));
    endtask

    task automatic test_wrap();
        logic [W-1:0] all1;
        logic [W-1:0] want;
        all1 = '1;
        want = '0;
        want = want - W'(8);
        run_single("wrap", all1, want);
    endtask

    task automatic test_back_to_back();
        logic [8*W-1:0] ops_arr [4];
        logic acc, ov, fired, pov;
        logic [W-1:0] s, c, ps, pc;
        logic [3:0] t, pt;
        int idx, nout, f0, fl;
        exp_t e;
        for (int i = 0; i < 4; i++) ops_arr[i] = rand_ops()[8*W-1:0];
        idx = 0; pov = 1'b0; ps = '0; pc = '0; pt = '0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive_cycle(idx < 4, ops_arr[idx % 4], 4'(idx), 1'b0, 1'b0, acc, ov, fired, s, c, t);
            if (acc) begin
                e.sum = ref_sum({{(25*W){1'b0}}, ops_arr[idx]}, 8); e.tag = 4'(idx);
                q.push_back(e); idx++;
            end
            if (pov && ov) begin
                n_cmp++;
                if (s !== ps || c !== pc || t !== pt) begin
                    n_err++; $display("FAIL stall_stable: got tag=%0h sum=%0h want tag=%0h sum=%0h", t, s, pt, ps);
                end
            end
            pov = ov; ps = s; pc = c; pt = t;
        end
        n_cmp++;
        if (idx !== 2) begin n_err++; $display("FAIL capacity: got %0d accepts want 2", idx); end
        nout = 0; f0 = -1; fl = -1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            drive_cycle(idx < 4, ops_arr[idx % 4], 4'(idx), 1'b1, 1'b0, acc, ov, fired, s, c, t);
            if (acc) begin
                e.sum = ref_sum({{(25*W){1'b0}}, ops_arr[idx]}, 8); e.tag = 4'(idx);
                q.push_back(e); idx++;
            end
            if (fired) begin
                if (f0 < 0) f0 = cyc;
                fl = cyc;
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL drain_extra: got tag=%0h want none", t);
                end else begin
                    e = q.pop_front();
                    if (W'(s + c) !== e.sum || t !== 4'(nout)) begin
                        n_err++; $display("FAIL drain_order: got tag=%0h sum=%0h want tag=%0h sum=%0h",
                                          t, W'(s + c), nout, e.sum);
                    end
                end
                nout++;
            end
        end
        n_cmp++;
        if (nout !== 4 || fl - f0 !== 3) begin
            n_err++; $display("FAIL drain_rate: got %0d outs over %0d cycles want 4 over 3", nout, fl - f0);
        end
        q.delete();
    endtask

    task automatic test_flush();
        logic acc, ov, fired, bad;
        logic [W-1:0] s, c;
        logic [3:0] t;
        logic [8*W-1:0] ops;
        logic [W-1:0] want;
        drive_cycle(1'b1, rand_ops()[8*W-1:0], 4'd5, 1'b0, 1'b0, acc, ov, fired, s, c, t);
        drive_cycle(1'b1, rand_ops()[8*W-1:0], 4'd6, 1'b0, 1'b0, acc, ov, fired, s, c, t);
        drive_cycle(1'b1, rand_ops()[8*W-1:0], 4'd7, 1'b0, 1'b1, acc, ov, fired, s, c, t);
        drive_cycle(1'b0, '0, 4'd0, 1'b1, 1'b0, acc, ov, fired, s, c, t);
        n_cmp++;
        if (ov !== 1'b0) begin n_err++; $display("FAIL flush_next: got valid %0b want 0", ov); end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, '0, 4'd0, 1'b1, 1'b0, acc, ov, fired, s, c, t);
            if (ov) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin n_err++; $display("FAIL flush_stale: got stale valid %0b want 0", bad); end
        ops = rand_ops()[8*W-1:0];
        want = ref_sum({{(25*W){1'b0}}, ops}, 8);
        drive_cycle(1'b1, ops, 4'd9, 1'b1, 1'b0, acc, ov, fired, s, c, t);
        drive_cycle(1'b0, '0, 4'd0, 1'b1, 1'b0, acc, ov, fired, s, c, t);
        n_cmp++;
        if (ov !== 1'b0) begin n_err++; $display("FAIL flush_after_early: got valid %0b want 0", ov); end
        drive_cycle(1'b0, '0, 4'd0, 1'b1, 1'b0, acc, ov, fired, s, c, t);
        n_cmp++;
        if (ov !== 1'b1 || W'(s + c) !== want || t !== 4'd9) begin
            n_err++; $display("FAIL flush_after: got v=%0b sum=%0h tag=%0h want v=1 sum=%0h tag=9",
                              ov, W'(s + c), t, want);
        end
    endtask

    task automatic test_async_reset_random();
        logic acc, ov, fired, pov, pordy, v, ordy;
        logic [W-1:0] s, c, ps, pc;
        logic [3:0] t, pt, tg;
        logic [8*W-1:0] ops;
        int accepted, cyc;
        exp_t e;
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, rand_ops()[8*W-1:0], 4'hA, 1'b0, 1'b0, acc, ov, fired, s, c, t);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_carry !== '0 || out_tag !== 4'd0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL async_reset: got v=%0b s=%0h c=%0h t=%0h rdy=%0b want 0 0 0 0 1",
                              out_valid, out_sum, out_carry, out_tag, in_ready);
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        accepted = 0; cyc = 0; pov = 1'b0; pordy = 1'b1; ps = '0; pc = '0; pt = '0;
        while ((accepted < 100 || q.size() != 0) && cyc < 3000) begin
            v = (accepted < 100) && (($urandom % 4) != 0);
            ordy = (accepted >= 100) || (($urandom % 3) != 0);
            ops = rand_ops()[8*W-1:0];
            tg = 4'($urandom);
            drive_cycle(v, ops, tg, ordy, 1'b0, acc, ov, fired, s, c, t);
            if (pov && !pordy) begin
                n_cmp++;
                if (ov !== 1'b1 || s !== ps || c !== pc || t !== pt) begin
                    n_err++; $display("FAIL rand_hold: got v=%0b tag=%0h sum=%0h want v=1 tag=%0h sum=%0h",
                                      ov, t, s, pt, ps);
                end
            end
            if (acc) begin
                e.sum = ref_sum({{(25*W){1'b0}}, ops}, 8); e.tag = tg;
                q.push_back(e); accepted++;
            end
            if (fired) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_extra: got tag=%0h want none", t);
                end else begin
                    e = q.pop_front();
                    if (W'(s + c) !== e.sum || t !== e.tag || c[0] !== 1'b0) begin
                        n_err++; $display("FAIL rand_result: got tag=%0h sum=%0h want tag=%0h sum=%0h",
                                          t, W'(s + c), e.tag, e.sum);
                    end
                end
            end
            pov = ov; pordy = ordy; ps = s; pc = c; pt = t;
            cyc++;
        end
        n_cmp++;
        if (accepted !== 100 || q.size() !== 0) begin
            n_err++; $display("FAIL rand_complete: got %0d accepted %0d pending want 100 0", accepted, q.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_three_ops();
        d3_ops = {W'(6), W'(3), W'(5)};
        d3_tag_in = 4'hC;
        d3_valid = 1'b1;
        #1;
        n_cmp++;
        if (d3_ready !== 1'b1) begin n_err++; $display("FAIL three_ready: got %0b want 1", d3_ready); end
        @(posedge clk); #1;
        d3_valid = 1'b0;
        n_cmp++;
        if (d3_ovalid !== 1'b1 || d3_sum !== W'(0) || d3_carry !== W'(14) || d3_tag !== 4'hC) begin
            n_err++; $display("FAIL three_result: got v=%0b s=%0h c=%0h t=%0h want v=1 s=0 c=e t=c",
                              d3_ovalid, d3_sum, d3_carry, d3_tag);
        end
    endtask

    task automatic test_sweep();
        int nops [3];
        int lat_want [3];
        logic got [3];
        nops = '{4, 9, 33};
        lat_want = '{1, 2, 4};
        for (int rep = 0; rep < 8; rep++) begin
            sw_ops = rand_ops();
            sw_tag_in = 4'(rep);
            sw_valid = 1'b1;
            @(posedge clk); #1;
            sw_valid = 1'b0;
            for (int i = 0; i < 3; i++) got[i] = 1'b0;
            for (int cyc = 1; cyc <= 6; cyc++) begin
                for (int i = 0; i < 3; i++) begin
                    if (!got[i] && sw_ovalid[i]) begin
                        got[i] = 1'b1;
                        n_cmp++;
                        if (W'(sw_sum[i] + sw_carry[i]) !== ref_sum(sw_ops, nops[i]) ||
                            cyc !== lat_want[i] || sw_otag[i] !== 4'(rep)) begin
                            n_err++;
                            $display("FAIL sweep_n%0d: got sum=%0h lat=%0d tag=%0h want sum=%0h lat=%0d tag=%0h",
                                     nops[i], W'(sw_sum[i] + sw_carry[i]), cyc, sw_otag[i],
                                     ref_sum(sw_ops, nops[i]), lat_want[i], rep);
                        end
                    end
                end
                @(posedge clk); #1;
            end
            for (int i = 0; i < 3; i++) begin
                if (!got[i]) begin
                    n_cmp++; n_err++;
                    $display("FAIL sweep_timeout_n%0d: got no result want one", nops[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_async_reset_random();
        test_three_ops();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
